// File: rtl/packet_framer_pkg.sv
// Shared constants and types for the packet framer: the 768-bit frame layout,
// the PNG signature, and the FSM state encoding.
package packet_framer_pkg;

  localparam int FRAME_W      = 768;
  localparam int BEAT_W       = 256;
  localparam int PAYLOAD_W    = 336;
  localparam int IP_W         = 32;
  localparam int PORT_W       = 16;
  localparam int SRC_IP_LSB   = 656;
  localparam int DST_IP_LSB   = 624;
  localparam int SRC_PORT_LSB = 496;
  localparam int DST_PORT_LSB = 480;
  localparam int PNG_LSB      = 272;
  localparam int PNG_W        = 64;
  localparam int CNT_W        = 16;

  localparam logic [PNG_W-1:0] PNG_SIGNATURE = 64'h89504E470D0A1A0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_BEAT2 = 2'd3
  } state_e;

  typedef logic [FRAME_W-1:0] frame_t;

  // Places every header field at its fixed offset; unlisted bits stay zero.
  function automatic frame_t build_frame(input logic [IP_W-1:0]      src_ip,
                                         input logic [IP_W-1:0]      dst_ip,
                                         input logic [PORT_W-1:0]    src_port,
                                         input logic [PORT_W-1:0]    dst_port,
                                         input logic [PAYLOAD_W-1:0] payload);
    frame_t f;
    f = '0;
    f[SRC_IP_LSB   +: IP_W]      = src_ip;
    f[DST_IP_LSB   +: IP_W]      = dst_ip;
    f[SRC_PORT_LSB +: PORT_W]    = src_port;
    f[DST_PORT_LSB +: PORT_W]    = dst_port;
    f[0            +: PAYLOAD_W] = payload;
    return f;
  endfunction

endpackage

// File: rtl/pkt_stats_cnt.sv
// One 16-bit event counter that wraps from 16'hFFFF to 0.
module pkt_stats_cnt
  import packet_framer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/packet_framer.sv
// Serialises a 768-bit header+payload frame into three 256-bit stream beats.
// Optional statistics counters are built only when PACKET_FRAMER_STATS_EN is defined.
module packet_framer
  import packet_framer_pkg::*;
#(
  parameter int          DATA_WIDTH = 256,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [31:0] SRC_IP     = 32'h0A000001,
  parameter logic [15:0] SRC_PORT   = 16'd5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic [IP_W-1:0]       in_dest_ip,
  input  logic [PORT_W-1:0]     in_dest_port,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [KEEP_WIDTH-1:0] tx_keep,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [CNT_W-1:0]      tx_pkt_count,
  output logic [CNT_W-1:0]      tx_png_count
);

  if (DATA_WIDTH != BEAT_W) begin : g_bad_width
    $error("packet_framer: DATA_WIDTH must be 256");
  end

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] BEAT0 = ST_BEAT0;
  localparam logic [1:0] BEAT1 = ST_BEAT1;
  localparam logic [1:0] BEAT2 = ST_BEAT2;

  logic [1:0] state;
  frame_t     shadow;
  logic       accept;
  logic       beat_hs;

  assign in_ready = (state == IDLE);
  assign tx_valid = (state != IDLE);
  assign tx_last  = (state == BEAT2);
  assign tx_keep  = {KEEP_WIDTH{tx_valid}};
  assign accept   = in_valid && in_ready;
  assign beat_hs  = tx_valid && tx_ready;

  // NOTE: the shadow register is a plain wide flop, not a memory, so clearing it on reset is cheap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shadow <= '0;
    end else begin
      if (accept) begin
        shadow <= build_frame(SRC_IP, in_dest_ip, SRC_PORT, in_dest_port, in_payload);
      end
      case (state)
        IDLE:    if (accept)  state <= BEAT0;
        BEAT0:   if (beat_hs) state <= BEAT1;
        BEAT1:   if (beat_hs) state <= BEAT2;
        default: if (beat_hs) state <= IDLE;
      endcase
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    tx_data = '0;
    case (state)
      BEAT0:   tx_data = shadow[2*BEAT_W +: BEAT_W];
      BEAT1:   tx_data = shadow[BEAT_W   +: BEAT_W];
      BEAT2:   tx_data = shadow[0        +: BEAT_W];
      default: tx_data = '0;
    endcase
  end

`ifdef PACKET_FRAMER_STATS_EN
  logic frame_done;
  logic png_hit;

  assign frame_done = beat_hs && (state == BEAT2);
  assign png_hit    = (shadow[PNG_LSB +: PNG_W] == PNG_SIGNATURE);

  pkt_stats_cnt u_pkt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (frame_done),
    .count (tx_pkt_count)
  );

  pkt_stats_cnt u_png_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (frame_done && png_hit),
    .count (tx_png_count)
  );
`else
  assign tx_pkt_count = '0;
  assign tx_png_count = '0;
`endif

endmodule

// File: tb/tb_packet_framer.sv
// Directed self-checking bench for packet_framer plus a standalone wrap test of pkt_stats_cnt.
module tb_packet_framer;

`ifdef PACKET_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [335:0] in_payload;
  logic [31:0]  in_dest_ip;
  logic [15:0]  in_dest_port;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] tx_data;
  logic [31:0]  tx_keep;
  logic         tx_valid;
  logic         tx_last;
  logic         tx_ready;
  logic [15:0]  tx_pkt_count;
  logic [15:0]  tx_png_count;

  logic         cnt_rst;
  logic         cnt_inc;
  logic [15:0]  cnt_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  packet_framer dut (
    .clk          (clk),
    .rst          (rst),
    .in_payload   (in_payload),
    .in_dest_ip   (in_dest_ip),
    .in_dest_port (in_dest_port),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tx_data      (tx_data),
    .tx_keep      (tx_keep),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .tx_pkt_count (tx_pkt_count),
    .tx_png_count (tx_png_count)
  );

  pkt_stats_cnt u_cnt (
    .clk   (clk),
    .rst   (cnt_rst),
    .inc   (cnt_inc),
    .count (cnt_count)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [767:0] frame(input logic [31:0] dip, input logic [15:0] dport,
                                         input logic [335:0] pl);
    logic [767:0] f;
    f = '0;
    f[687:656] = 32'h0A000001;
    f[655:624] = dip;
    f[511:496] = 16'd5000;
    f[495:480] = dport;
    f[335:0]   = pl;
    return f;
  endfunction

  function automatic logic [255:0] beat(input logic [767:0] f, input int idx);
    case (idx)
      0:       return f[767:512];
      1:       return f[511:256];
      default: return f[255:0];
    endcase
  endfunction

  function automatic logic [15:0] stat(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic check_frame(input string tag, input logic [767:0] f);
    for (int b = 0; b < 3; b++) begin
      check({tag, "_valid"}, 256'(tx_valid), 256'd1);
      check({tag, "_data"},  tx_data, beat(f, b));
      check({tag, "_keep"},  256'(tx_keep), 256'hFFFF_FFFF);
      check({tag, "_last"},  256'(tx_last), (b == 2) ? 256'd1 : 256'd0);
      step();
    end
    check({tag, "_idle_valid"}, 256'(tx_valid), 256'd0);
    check({tag, "_idle_ready"}, 256'(in_ready), 256'd1);
  endtask

  initial begin
    logic [767:0] fa, fb, fd;
    logic [335:0] png_pl;
    logic [335:0] plain_pl;
    int           hs;
    int           beat_idx;
    int           beats;
    int           accepts;
    logic         pattern [6];

    png_pl   = {64'h89504E470D0A1A0A, 272'd0};
    plain_pl = {64'h0123456789ABCDEF, 208'd0, 64'hDEADBEEF_CAFEF00D};

    rst = 1'b0; cnt_rst = 1'b0; cnt_inc = 1'b0;
    in_valid = 1'b0; tx_ready = 1'b0;
    in_payload = '0; in_dest_ip = '0; in_dest_port = '0;

    // Reset state
    #3;
    check("rst_in_ready", 256'(in_ready), 256'd1);
    check("rst_tx_valid", 256'(tx_valid), 256'd0);
    check("rst_tx_last",  256'(tx_last),  256'd0);
    check("rst_tx_data",  tx_data,        256'd0);
    check("rst_tx_keep",  256'(tx_keep),  256'd0);
    check("rst_pkt",      256'(tx_pkt_count), 256'd0);
    check("rst_png",      256'(tx_png_count), 256'd0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_idle", 256'(tx_valid), 256'd0);

    // a: PNG frame, tx_ready held high
    fa = frame(32'hC0A80105, 16'h0015, png_pl);
    in_dest_ip = 32'hC0A80105; in_dest_port = 16'h0015; in_payload = png_pl;
    in_valid = 1'b1; tx_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("a_in_ready_busy", 256'(in_ready), 256'd0);
    check("a_beat0_dest_ip", 256'(tx_data[143:112]), 256'hC0A80105);
    check_frame("a", fa);
    check("a_pkt", 256'(tx_pkt_count), 256'(stat(1)));
    check("a_png", 256'(tx_png_count), 256'(stat(1)));

    // b: backpressure 1,0,0,1,0,1
    fb = frame(32'h0A0B0C0D, 16'h1F90, plain_pl);
    in_dest_ip = 32'h0A0B0C0D; in_dest_port = 16'h1F90; in_payload = plain_pl;
    in_valid = 1'b1; tx_ready = 1'b0;
    step();
    in_valid = 1'b0;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    hs = 0; beat_idx = 0;
    for (int i = 0; i < 6; i++) begin
      check("b_valid", 256'(tx_valid), 256'd1);
      check("b_data",  tx_data, beat(fb, beat_idx));
      check("b_last",  256'(tx_last), (beat_idx == 2) ? 256'd1 : 256'd0);
      tx_ready = pattern[i];
      if (tx_valid && tx_ready) begin
        hs++;
        beat_idx++;
      end
      step();
    end
    check("b_handshakes", 256'(hs), 256'd3);
    check("b_in_ready",   256'(in_ready), 256'd1);
    check("b_tx_valid",   256'(tx_valid), 256'd0);
    check("b_pkt",        256'(tx_pkt_count), 256'(stat(2)));
    check("b_png_unchanged", 256'(tx_png_count), 256'(stat(1)));

    // c: back-to-back requests, fresh counters
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tx_ready = 1'b1; in_valid = 1'b1;
    beats = 0; accepts = 0;
    for (int c = 0; c < 16; c++) begin
      if (tx_valid) beats++;
      if (in_ready) accepts++;
      step();
    end
    in_valid = 1'b0;
    check("c_beats",    256'(beats),   256'd12);
    check("c_accepts",  256'(accepts), 256'd4);
    check("c_in_ready", 256'(in_ready), 256'd1);
    check("c_pkt",      256'(tx_pkt_count), 256'(stat(4)));
    check("c_png",      256'(tx_png_count), 256'(stat(0)));

    // d: reset asserted during BEAT1 aborts the frame
    in_dest_ip = 32'hC0A80105; in_dest_port = 16'h0015; in_payload = png_pl;
    in_valid = 1'b1; tx_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("d_beat1_data", tx_data, beat(fa, 1));
    #2;
    rst = 1'b0;
    #1;
    check("d_abort_valid", 256'(tx_valid), 256'd0);
    check("d_abort_last",  256'(tx_last),  256'd0);
    check("d_abort_data",  tx_data,        256'd0);
    check("d_abort_keep",  256'(tx_keep),  256'd0);
    check("d_abort_ready", 256'(in_ready), 256'd1);
    check("d_abort_pkt",   256'(tx_pkt_count), 256'd0);
    fd = frame(32'h08080808, 16'h0035, plain_pl);
    in_dest_ip = 32'h08080808; in_dest_port = 16'h0035; in_payload = plain_pl;
    in_valid = 1'b1;
    #1;
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    check_frame("d", fd);
    check("d_pkt", 256'(tx_pkt_count), 256'(stat(1)));
    check("d_png_unchanged", 256'(tx_png_count), 256'(stat(0)));

    // e: counter wrap at 16 bits
    cnt_rst = 1'b1;
    step();
    check("e_cnt_start", 256'(cnt_count), 256'd0);
    cnt_inc = 1'b1;
    repeat (65535) step();
    check("e_cnt_max", 256'(cnt_count), 256'hFFFF);
    step();
    check("e_cnt_wrap", 256'(cnt_count), 256'd0);
    cnt_inc = 1'b0;
    step();
    check("e_cnt_hold", 256'(cnt_count), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
